// File: rtl/mbist_pkg.sv
// Shared types and constants for the MBIST sequencer.
// State encoding and pattern-selector bounds.
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CMP,
    S_DONE
  } mbist_state_e;

  typedef logic [2:0] pat_sel_t;

  localparam int       NUM_PATTERNS = 6;
  localparam pat_sel_t LAST_PAT     = 3'd5;

endpackage

// File: rtl/mbist_addr_gen.sv
// SRAM address counter for the MBIST sequencer.
// Clear has priority over increment; last flags the top address.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == MAX_ADDR);

endmodule

// File: rtl/mbist_ctrl.sv
// MBIST sequencer: write/read-compare each background pattern
// over the whole SRAM and capture the first miscompare.
module mbist_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [2:0]        q,
  input  logic [DATA_W-1:0] data_t,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_pat
);

  import mbist_pkg::*;

  mbist_state_e      r_state;
  mbist_state_e      w_next;
  pat_sel_t          r_q;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  pat_sel_t          r_fail_pat;

  logic              w_clr;
  logic              w_inc;
  logic              w_start;
  logic              w_q_inc;
  logic              w_cap;
  logic              w_miss;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  assign w_miss = (mem_rdata != data_t);

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    w_start = 1'b0;
    w_q_inc = 1'b0;
    w_cap   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next  = S_WRITE;
          w_clr   = 1'b1;
          w_start = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_clr  = 1'b1;
          w_next = S_READ;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_READ: w_next = S_CMP;
      S_CMP: begin
        w_cap = w_miss && !r_fail;
        if (w_miss && STOP_ON_FAIL) begin
          w_next = S_DONE;
        end else if (!w_last) begin
          w_inc  = 1'b1;
          w_next = S_READ;
        end else if (r_q == LAST_PAT) begin
          w_next = S_DONE;
        end else begin
          w_q_inc = 1'b1;
          w_clr   = 1'b1;
          w_next  = S_WRITE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_pat  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE) && !w_start;
      if (w_start) begin
        r_q <= '0;
      end else if (w_q_inc) begin
        r_q <= r_q + 3'd1;
      end
      if (w_start) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_pat  <= '0;
      end else if (w_cap) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_addr;
        r_fail_pat  <= r_q;
      end
    end
  end

  // Strobes decode straight from state so reset kills them at once
  assign mem_we    = (r_state == S_WRITE);
  assign mem_re    = (r_state == S_READ);
  assign mem_addr  = w_addr;
  assign mem_wdata = data_t;
  assign busy      = (r_state == S_WRITE) ||
                     (r_state == S_READ)  ||
                     (r_state == S_CMP);
  assign done      = r_done;
  assign q         = r_q;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_pat  = r_fail_pat;

endmodule
